// File: rtl/ex_stage_pkg.sv
// Shared types for the RV32I execute stage:
// ALU op encodings, funct codes, ALU control and forwarding selects.
package ex_stage_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [1:0] ALU_OP_ADD = 2'b00;
    localparam logic [1:0] ALU_OP_SUB = 2'b01;
    localparam logic [1:0] ALU_OP_R   = 2'b10;
    localparam logic [1:0] ALU_OP_I   = 2'b11;

    localparam logic [3:0] FN_ADD  = 4'b0000;
    localparam logic [3:0] FN_SUB  = 4'b1000;
    localparam logic [3:0] FN_AND  = 4'b0111;
    localparam logic [3:0] FN_OR   = 4'b0110;
    localparam logic [3:0] FN_XOR  = 4'b0100;
    localparam logic [3:0] FN_SLL  = 4'b0001;
    localparam logic [3:0] FN_SRL  = 4'b0101;
    localparam logic [3:0] FN_SRA  = 4'b1101;
    localparam logic [3:0] FN_SLT  = 4'b0010;
    localparam logic [3:0] FN_SLTU = 4'b0011;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU,
        ALU_NOP
    } alu_ctl_e;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    // I-type ignores funct7[5] except to pick sra over srl.
    function automatic alu_ctl_e alu_decode(
        input logic [1:0] op,
        input logic [3:0] fn
    );
        alu_ctl_e c;
        c = ALU_NOP;
        case (op)
            ALU_OP_ADD: c = ALU_ADD;
            ALU_OP_SUB: c = ALU_SUB;
            ALU_OP_R: begin
                case (fn)
                    FN_ADD:  c = ALU_ADD;
                    FN_SUB:  c = ALU_SUB;
                    FN_AND:  c = ALU_AND;
                    FN_OR:   c = ALU_OR;
                    FN_XOR:  c = ALU_XOR;
                    FN_SLL:  c = ALU_SLL;
                    FN_SRL:  c = ALU_SRL;
                    FN_SRA:  c = ALU_SRA;
                    FN_SLT:  c = ALU_SLT;
                    FN_SLTU: c = ALU_SLTU;
                    default: c = ALU_NOP;
                endcase
            end
            default: begin
                case (fn[2:0])
                    3'b000:  c = ALU_ADD;
                    3'b111:  c = ALU_AND;
                    3'b110:  c = ALU_OR;
                    3'b100:  c = ALU_XOR;
                    3'b001:  c = ALU_SLL;
                    3'b101:  c = fn[3] ? ALU_SRA : ALU_SRL;
                    3'b010:  c = ALU_SLT;
                    default: c = ALU_SLTU;
                endcase
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX pipeline bundle consumed by the execute stage.
// master = ID/EX register side, slave = execute stage.
interface ex_stage_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              mem_to_reg;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              beq;
    logic              alu_src;
    logic [1:0]        alu_op;
    logic [3:0]        funct;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rf_rdata1;
    logic [XLEN-1:0]   rf_rdata2;

    modport master (
        output mem_to_reg, reg_write, mem_read, mem_write,
        output beq, alu_src, alu_op, funct,
        output rs1, rs2, rd, imm, pc,
        output rf_rdata1, rf_rdata2
    );

    modport slave (
        input mem_to_reg, reg_write, mem_read, mem_write,
        input beq, alu_src, alu_op, funct,
        input rs1, rs2, rd, imm, pc,
        input rf_rdata1, rf_rdata2
    );
endinterface

// File: rtl/ex_stage_alu.sv
// Combinational ALU: operand B mux, operation select,
// and the rs1/rs2 equality flag used by beq.
module ex_stage_alu
    import ex_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_ctl_e        ctl,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] imm,
    input  logic            use_imm,
    output logic [XLEN-1:0] result,
    output logic            zero
);
    logic [XLEN-1:0] b;
    logic [4:0]      shamt;

    assign b     = use_imm ? imm : rs2_val;
    assign shamt = b[4:0];

    // zero compares the register operands, never the immediate
    assign zero = ((a - rs2_val) == '0);

    // operation select; unknown control yields 0
    always_comb begin
        result = '0;
        case (ctl)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, a < b};
            default:  result = '0;
        endcase
    end
endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, beq resolve
// and the EX/MEM pipeline register.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    ex_stage_if.slave         idex,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              wb_reg_write_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic [XLEN-1:0]   wb_wdata_i,
    output logic              branch_taken_o,
    output logic [XLEN-1:0]   branch_target_o,
    output logic              mem_to_reg_o,
    output logic              reg_write_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [XLEN-1:0]   alu_result_o,
    output logic [XLEN-1:0]   store_data_o,
    output logic [REG_AW-1:0] rd_o
);
    fwd_sel_e        sel_a;
    fwd_sel_e        sel_b;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic [XLEN-1:0] alu_res;
    logic            zero;
    logic            ex_hit_a;
    logic            ex_hit_b;
    logic            wb_hit_a;
    logic            wb_hit_b;

    assign ex_hit_a = reg_write_o && rd_o != '0 && rd_o == idex.rs1;
    assign ex_hit_b = reg_write_o && rd_o != '0 && rd_o == idex.rs2;
    assign wb_hit_a = wb_reg_write_i && wb_rd_i != '0 && wb_rd_i == idex.rs1;
    assign wb_hit_b = wb_reg_write_i && wb_rd_i != '0 && wb_rd_i == idex.rs2;

    // forward select, EX/MEM ahead of MEM/WB
    always_comb begin
        sel_a = FWD_RF;
        sel_b = FWD_RF;
        if (ex_hit_a)      sel_a = FWD_EXMEM;
        else if (wb_hit_a) sel_a = FWD_MEMWB;
        if (ex_hit_b)      sel_b = FWD_EXMEM;
        else if (wb_hit_b) sel_b = FWD_MEMWB;
    end

    // forwarded operand values
    always_comb begin
        opa = idex.rf_rdata1;
        opb = idex.rf_rdata2;
        case (sel_a)
            FWD_EXMEM: opa = alu_result_o;
            FWD_MEMWB: opa = wb_wdata_i;
            default:   opa = idex.rf_rdata1;
        endcase
        case (sel_b)
            FWD_EXMEM: opb = alu_result_o;
            FWD_MEMWB: opb = wb_wdata_i;
            default:   opb = idex.rf_rdata2;
        endcase
    end

    ex_stage_alu #(.XLEN(XLEN)) u_alu (
        .ctl     (alu_decode(idex.alu_op, idex.funct)),
        .a       (opa),
        .rs2_val (opb),
        .imm     (idex.imm),
        .use_imm (idex.alu_src),
        .result  (alu_res),
        .zero    (zero)
    );

    assign branch_taken_o  = idex.beq & zero & ~stall_i & ~reset;
    assign branch_target_o = idex.pc + idex.imm;

    // EX/MEM register: flush bubbles control, stall holds
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_to_reg_o <= 1'b0;
            reg_write_o  <= 1'b0;
            mem_read_o   <= 1'b0;
            mem_write_o  <= 1'b0;
            alu_result_o <= '0;
            store_data_o <= '0;
            rd_o         <= '0;
        end else if (flush_i || !stall_i) begin
            mem_to_reg_o <= flush_i ? 1'b0 : idex.mem_to_reg;
            reg_write_o  <= flush_i ? 1'b0
                          : (idex.reg_write && idex.rd != '0);
            mem_read_o   <= flush_i ? 1'b0 : idex.mem_read;
            mem_write_o  <= flush_i ? 1'b0 : idex.mem_write;
            alu_result_o <= alu_res;
            store_data_o <= opb;
            rd_o         <= idex.rd;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// Randomized bench for ex_stage against a behavioural
// EX/MEM model, plus literal checks on directed cases.
module tb_ex_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i;
    logic        flush_i;
    logic        wb_reg_write_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_wdata_i;
    logic        branch_taken_o;
    logic [31:0] branch_target_o;
    logic        mem_to_reg_o;
    logic        reg_write_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic [31:0] alu_result_o;
    logic [31:0] store_data_o;
    logic [4:0]  rd_o;

    int checks   = 0;
    int failures = 0;

    logic        m_mtr, m_rw, m_mr, m_mw;
    logic [31:0] m_res, m_sd;
    logic [4:0]  m_rd;

    logic [3:0] fn_tab [12] = '{4'h0, 4'h8, 4'h7, 4'h6, 4'h4, 4'h1,
                                4'h5, 4'hd, 4'h2, 4'h3, 4'hf, 4'h9};

    always #5 clk = ~clk;

    ex_stage_if bus ();

    ex_stage dut (
        .clk             (clk),
        .reset           (reset),
        .idex            (bus),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .wb_reg_write_i  (wb_reg_write_i),
        .wb_rd_i         (wb_rd_i),
        .wb_wdata_i      (wb_wdata_i),
        .branch_taken_o  (branch_taken_o),
        .branch_target_o (branch_target_o),
        .mem_to_reg_o    (mem_to_reg_o),
        .reg_write_o     (reg_write_o),
        .mem_read_o      (mem_read_o),
        .mem_write_o     (mem_write_o),
        .alu_result_o    (alu_result_o),
        .store_data_o    (store_data_o),
        .rd_o            (rd_o)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [1:0] op,
        input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] sh;
        logic [3:0] f;
        sh = b[4:0];
        if (op == 2'b00) return a + b;
        if (op == 2'b01) return a - b;
        f = fn;
        if (op == 2'b11) f = (fn[2:0] == 3'b101) ? fn : {1'b0, fn[2:0]};
        case (f)
            4'h0: return a + b;
            4'h8: return a - b;
            4'h7: return a & b;
            4'h6: return a | b;
            4'h4: return a ^ b;
            4'h1: return a << sh;
            4'h5: return a >> sh;
            4'hd: return $unsigned($signed(a) >>> sh);
            4'h2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h3: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] rs,
                                        input logic [31:0] rf);
        if (m_rw && m_rd != 0 && m_rd == rs) return m_res;
        if (wb_reg_write_i && wb_rd_i != 0 && wb_rd_i == rs) return wb_wdata_i;
        return rf;
    endfunction

    task automatic model_clear();
        m_mtr = 0; m_rw = 0; m_mr = 0; m_mw = 0;
        m_res = 0; m_sd = 0; m_rd = 0;
    endtask

    task automatic chk_regs();
        chk("mem_to_reg", {31'b0, mem_to_reg_o}, {31'b0, m_mtr});
        chk("reg_write", {31'b0, reg_write_o}, {31'b0, m_rw});
        chk("mem_read", {31'b0, mem_read_o}, {31'b0, m_mr});
        chk("mem_write", {31'b0, mem_write_o}, {31'b0, m_mw});
        chk("alu_result", alu_result_o, m_res);
        chk("store_data", store_data_o, m_sd);
        chk("rd", {27'b0, rd_o}, {27'b0, m_rd});
    endtask

    task automatic tick();
        logic [31:0] fa, fb, res;
        logic        bt, lu;
        fa  = fwd(bus.rs1, bus.rf_rdata1);
        fb  = fwd(bus.rs2, bus.rf_rdata2);
        res = ref_alu(bus.alu_op, bus.funct, fa,
                      bus.alu_src ? bus.imm : fb);
        bt  = bus.beq && (fa == fb) && !stall_i && !reset;
        @(negedge clk);
        lu = mem_read_o && reg_write_o && rd_o != 0 &&
             (rd_o == bus.rs1 || rd_o == bus.rs2);
        chk("load_use", {31'b0, lu}, 32'd0);
        chk("br_taken", {31'b0, branch_taken_o}, {31'b0, bt});
        chk("br_target", branch_target_o, bus.pc + bus.imm);
        @(posedge clk);
        if (reset) begin
            model_clear();
        end else if (flush_i) begin
            m_mtr = 0; m_rw = 0; m_mr = 0; m_mw = 0;
            m_res = res; m_sd = fb; m_rd = bus.rd;
        end else if (!stall_i) begin
            m_mtr = bus.mem_to_reg;
            m_rw  = bus.reg_write && bus.rd != 0;
            m_mr  = bus.mem_read;
            m_mw  = bus.mem_write;
            m_res = res; m_sd = fb; m_rd = bus.rd;
        end
        #1;
        chk_regs();
    endtask

    task automatic idle();
        bus.mem_to_reg = 0; bus.reg_write = 0; bus.mem_read = 0;
        bus.mem_write = 0; bus.beq = 0; bus.alu_src = 0;
        bus.alu_op = 0; bus.funct = 0;
        bus.rs1 = 0; bus.rs2 = 0; bus.rd = 0;
        bus.imm = 0; bus.pc = 0; bus.rf_rdata1 = 0; bus.rf_rdata2 = 0;
        stall_i = 0; flush_i = 0;
        wb_reg_write_i = 0; wb_rd_i = 0; wb_wdata_i = 0;
    endtask

    initial begin
        reset = 1;
        idle();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_alu", alu_result_o, 32'd0);
        chk("rst_rw", {31'b0, reg_write_o}, 32'd0);
        chk("rst_rd", {27'b0, rd_o}, 32'd0);
        chk_regs();
        reset = 0;

        // R-type add
        idle();
        bus.alu_op = 2'b10; bus.funct = 4'h0;
        bus.rs1 = 1; bus.rs2 = 2; bus.rd = 3; bus.reg_write = 1;
        bus.rf_rdata1 = 5; bus.rf_rdata2 = 7;
        tick();
        chk("add_lit", alu_result_o, 32'd12);
        chk("add_rd", {27'b0, rd_o}, 32'd3);
        chk("add_rw", {31'b0, reg_write_o}, 32'd1);

        // sub with EX/MEM beating MEM/WB
        idle();
        bus.alu_op = 2'b10; bus.funct = 4'h8;
        bus.rs1 = 3; bus.rs2 = 4; bus.rd = 5; bus.reg_write = 1;
        bus.rf_rdata1 = 0; bus.rf_rdata2 = 2;
        wb_reg_write_i = 1; wb_rd_i = 3; wb_wdata_i = 99;
        tick();
        chk("fwd_lit", alu_result_o, 32'd10);

        // beq taken, then suppressed by stall
        idle();
        bus.beq = 1; bus.alu_op = 2'b01;
        bus.rs1 = 6; bus.rs2 = 7;
        bus.rf_rdata1 = 4; bus.rf_rdata2 = 4;
        bus.pc = 32'h100; bus.imm = 32'h20;
        #1;
        chk("beq_lit", {31'b0, branch_taken_o}, 32'd1);
        chk("beq_tgt", branch_target_o, 32'h120);
        tick();
        stall_i = 1;
        #1;
        chk("beq_stall", {31'b0, branch_taken_o}, 32'd0);
        tick();

        // sw address and data
        idle();
        bus.alu_src = 1; bus.alu_op = 2'b00; bus.mem_write = 1;
        bus.rs1 = 8; bus.rs2 = 9;
        bus.rf_rdata1 = 32'h1000; bus.imm = 8;
        bus.rf_rdata2 = 32'hDEADBEEF;
        tick();
        chk("sw_addr", alu_result_o, 32'h1008);
        chk("sw_data", store_data_o, 32'hDEADBEEF);
        chk("sw_mw", {31'b0, mem_write_o}, 32'd1);

        // hold for two stalled cycles
        bus.rf_rdata1 = 32'h2000; bus.imm = 4;
        stall_i = 1;
        repeat (2) tick();
        chk("stall_hold", alu_result_o, 32'h1008);
        chk("stall_mw", {31'b0, mem_write_o}, 32'd1);

        // flush beats stall; data still loads
        flush_i = 1;
        tick();
        chk("flush_mw", {31'b0, mem_write_o}, 32'd0);
        chk("flush_data", alu_result_o, 32'h2004);

        // write to x0 never reaches reg_write_o
        idle();
        bus.reg_write = 1; bus.rd = 0;
        bus.rf_rdata1 = 3; bus.rf_rdata2 = 4;
        tick();
        chk("x0_rw", {31'b0, reg_write_o}, 32'd0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            bus.alu_op = 2'($urandom_range(0, 3));
            bus.funct = fn_tab[$urandom_range(0, 11)];
            bus.rs1 = 5'($urandom_range(0, 7));
            bus.rs2 = 5'($urandom_range(0, 7));
            bus.rd = 5'($urandom_range(0, 7));
            bus.rf_rdata1 = $urandom;
            bus.rf_rdata2 = ($urandom_range(0, 3) == 0) ? bus.rf_rdata1
                                                        : $urandom;
            bus.imm = $urandom;
            bus.pc = $urandom;
            bus.alu_src = 1'($urandom_range(0, 1));
            bus.beq = ($urandom_range(0, 5) == 0);
            if (bus.beq) begin
                bus.reg_write = 0; bus.mem_write = 0; bus.mem_read = 0;
                bus.alu_src = 0; bus.alu_op = 2'b01;
            end else begin
                bus.reg_write = 1'($urandom_range(0, 1));
                bus.mem_read = ($urandom_range(0, 3) == 0);
                bus.mem_write = !bus.mem_read && ($urandom_range(0, 3) == 0);
            end
            bus.mem_to_reg = bus.mem_read;
            stall_i = ($urandom_range(0, 6) == 0);
            flush_i = ($urandom_range(0, 9) == 0);
            wb_reg_write_i = 1'($urandom_range(0, 1));
            wb_rd_i = 5'($urandom_range(0, 7));
            wb_wdata_i = $urandom;
            if (m_mr && m_rw && m_rd != 0) begin
                if (bus.rs1 == m_rd) bus.rs1 = m_rd ^ 5'd8;
                if (bus.rs2 == m_rd) bus.rs2 = m_rd ^ 5'd8;
            end
            tick();
        end

        // async reset in the middle of an sra
        idle();
        bus.alu_op = 2'b00; bus.rs1 = 1; bus.rs2 = 2; bus.rd = 4;
        bus.reg_write = 1; bus.rf_rdata1 = 1; bus.rf_rdata2 = 1;
        tick();
        idle();
        bus.alu_op = 2'b10; bus.funct = 4'hd;
        bus.rs1 = 10; bus.rs2 = 11; bus.rd = 12; bus.reg_write = 1;
        bus.rf_rdata1 = 32'h80000000; bus.rf_rdata2 = 4;
        #2;
        reset = 1;
        #1;
        chk("arst_alu", alu_result_o, 32'd0);
        chk("arst_rw", {31'b0, reg_write_o}, 32'd0);
        chk("arst_rd", {27'b0, rd_o}, 32'd0);
        model_clear();
        chk_regs();
        tick();
        reset = 0;
        tick();
        chk("sra_lit", alu_result_o, 32'hF8000000);
        chk("sra_rd", {27'b0, rd_o}, 32'd12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
